// File: rtl/cgra_ctx_sequencer_if.sv
// Frame stream between the context sequencer and a cgra_pe.
// The sequencer is master: it drives the frame and valid, and the PE returns ready.
interface cgra_ctx_sequencer_if #(
  parameter int FRAME_WIDTH = 64
);
  logic [FRAME_WIDTH-1:0] config_frame;
  logic                   config_valid;
  logic                   pe_ready;

  modport master (output config_frame, output config_valid, input pe_ready);
  modport slave  (input config_frame, input config_valid, output pe_ready);
endinterface

// File: rtl/cgra_ctx_sequencer.sv
// Context-frame sequencer: replays a programmed list of PE config frames for N loops.
// Optional stall counter output is enabled by defining CGRA_CTX_PERF_EN.
module cgra_ctx_sequencer #(
  parameter int FRAME_WIDTH = 64,
  parameter int CTX_DEPTH   = 16,
  parameter int ADDR_W      = $clog2(CTX_DEPTH),
  parameter int LOOP_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [FRAME_WIDTH-1:0] wr_data,
  output logic                   wr_err,
  input  logic                   start,
  input  logic                   stop,
  input  logic [ADDR_W:0]        ctx_len,
  input  logic [LOOP_WIDTH-1:0]  loop_count,
  cgra_ctx_sequencer_if.master   pe,
  output logic                   busy,
  output logic                   done,
  output logic                   start_err,
  output logic [ADDR_W-1:0]      ctx_ptr,
  output logic [LOOP_WIDTH-1:0]  loop_iter
`ifdef CGRA_CTX_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = CTX_DEPTH[ADDR_W:0];

  state_t                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] mem [CTX_DEPTH];
  logic [ADDR_W:0]        len_q;
  logic [LOOP_WIDTH-1:0]  loops_q;

  logic                   accept;
  logic                   len_ok;
  logic                   last_frame;
  logic                   finish;
  logic                   launch;
  logic [ADDR_W-1:0]      next_ptr;
  logic [LOOP_WIDTH-1:0]  iter_inc;
  logic [FRAME_WIDTH-1:0] first_frame;

  assign accept      = pe.config_valid && pe.pe_ready;
  assign len_ok      = (ctx_len != '0) && (ctx_len <= DEPTH_L);
  assign launch      = (state_q == S_IDLE) && start && len_ok;
  assign last_frame  = ({1'b0, ctx_ptr} == (len_q - 1'b1));
  assign iter_inc    = loop_iter + 1'b1;
  assign next_ptr    = ctx_ptr + 1'b1;
  assign finish      = (state_q == S_RUN) && accept && last_frame &&
                       (loops_q != '0) && (iter_inc == loops_q);
  // Same-cycle host write to entry 0 must show up in the very first frame.
  assign first_frame = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];

  // NOTE: context storage has no reset; only the control path needs a known state.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first keeps this combinational process latch-free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && len_ok) state_d = S_RUN;
      S_RUN:  if (finish || stop)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe.config_frame <= '0;
      pe.config_valid <= 1'b0;
      done            <= 1'b0;
      wr_err          <= 1'b0;
      start_err       <= 1'b0;
      ctx_ptr         <= '0;
      loop_iter       <= '0;
      len_q           <= '0;
      loops_q         <= '0;
    end else begin
      done      <= 1'b0;
      wr_err    <= 1'b0;
      start_err <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q           <= ctx_len;
              loops_q         <= loop_count;
              ctx_ptr         <= '0;
              loop_iter       <= '0;
              pe.config_frame <= first_frame;
              pe.config_valid <= 1'b1;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (wr_en) wr_err <= 1'b1;
          if (accept) begin
            if (!last_frame) begin
              ctx_ptr         <= next_ptr;
              pe.config_frame <= mem[next_ptr];
            end else begin
              loop_iter <= iter_inc;
              if (finish) begin
                pe.config_valid <= 1'b0;
                done            <= 1'b1;
              end else begin
                ctx_ptr         <= '0;
                pe.config_frame <= mem[0];
              end
            end
          end
          // Completion takes priority over an abort arriving in the same cycle.
          if (stop && !finish) pe.config_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CGRA_CTX_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (launch) begin
      stall_cycles <= '0;
    end else if ((state_q == S_RUN) && pe.config_valid && !pe.pe_ready &&
                 (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cgra_ctx_sequencer.sv
// Self-checking bench for cgra_ctx_sequencer: random frames and handshake stalls
// compared against a list-replay model (frame k of a run is mem[k mod len]).
module tb_cgra_ctx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_err;
  logic        start;
  logic        stop;
  logic [4:0]  ctx_len;
  logic [15:0] loop_count;
  logic        busy;
  logic        done;
  logic        start_err;
  logic [3:0]  ctx_ptr;
  logic [15:0] loop_iter;
`ifdef CGRA_CTX_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] model_mem [16];

  cgra_ctx_sequencer_if #(.FRAME_WIDTH(64)) pe_bus ();

  cgra_ctx_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .start      (start),
    .stop       (stop),
    .ctx_len    (ctx_len),
    .loop_count (loop_count),
    .pe         (pe_bus),
    .busy       (busy),
    .done       (done),
    .start_err  (start_err),
    .ctx_ptr    (ctx_ptr),
    .loop_iter  (loop_iter)
`ifdef CGRA_CTX_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic [63:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic program_entries(input int n);
    for (int i = 0; i < n; i++) write_entry(i, {$urandom, $urandom});
  endtask

  task automatic pulse_start(input int len, input int loops);
    ctx_len    = 5'(len);
    loop_count = 16'(loops);
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams n_acc accepts with random ready; checks every presented cycle and the
  // completion pulse when the run is finite and n_acc covers it.
  task automatic run_stream(input int len, input int loops, input int n_acc,
                            input int ready_pct, input string tag);
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    logic [63:0] ef;
    logic [3:0]  ep;
    logic [15:0] ei;
    pulse_start(len, loops);
    while (k < n_acc && cyc < 4000) begin
      ef = model_mem[k % len];
      ep = 4'(k % len);
      ei = 16'(k / len);
      checks++;
      if (pe_bus.config_valid !== 1'b1 || pe_bus.config_frame !== ef) begin
        errors++;
        $display("FAIL %s frame k=%0d: valid=%b frame=%h, want valid=1 frame=%h",
                 tag, k, pe_bus.config_valid, pe_bus.config_frame, ef);
      end
      checks++;
      if (ctx_ptr !== ep || loop_iter !== ei || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s status k=%0d: ptr=%0d iter=%0d busy=%b done=%b, want ptr=%0d iter=%0d busy=1 done=0",
                 tag, k, ctx_ptr, loop_iter, busy, done, ep, ei);
      end
      pe_bus.pe_ready = ($urandom_range(0, 99) < ready_pct);
      if (pe_bus.pe_ready) k++;
      else stalls++;
      tick();
      cyc++;
    end
    pe_bus.pe_ready = 1'b0;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s timeout: accepts=%0d, want %0d", tag, k, n_acc);
    end
    if (loops != 0 && n_acc == len * loops) begin
      checks++;
      if (done !== 1'b1 || pe_bus.config_valid !== 1'b0 || busy !== 1'b0 || loop_iter !== 16'(loops)) begin
        errors++;
        $display("FAIL %s completion: done=%b valid=%b busy=%b iter=%0d, want 1 0 0 %0d",
                 tag, done, pe_bus.config_valid, busy, loop_iter, loops);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s done width: done=%b, want 0", tag, done);
      end
    end
`ifdef CGRA_CTX_PERF_EN
    checks++;
    if (stall_cycles !== 32'(stalls)) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, want %0d", tag, stall_cycles, stalls);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (pe_bus.config_frame !== 64'd0 || pe_bus.config_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || wr_err !== 1'b0 || start_err !== 1'b0 || ctx_ptr !== 4'd0 || loop_iter !== 16'd0) begin
      errors++;
      $display("FAIL reset: frame=%h valid=%b busy=%b done=%b wr_err=%b start_err=%b ptr=%0d iter=%0d, want all 0",
               pe_bus.config_frame, pe_bus.config_valid, busy, done, wr_err, start_err, ctx_ptr, loop_iter);
    end
`ifdef CGRA_CTX_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset stall_cycles: got %0d, want 0", stall_cycles);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    write_entry(0, 64'h0000_0000_0000_0001);
    write_entry(1, 64'h0000_0000_0000_0002);
    write_entry(2, 64'h0000_0000_0000_0004);
    run_stream(3, 2, 6, 100, "basic");
  endtask

  task automatic test_stall();
    int frames_held = 0;
    program_entries(3);
    pulse_start(3, 2);
    pe_bus.pe_ready = 1'b1;
    tick();
    pe_bus.pe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pe_bus.config_frame === model_mem[1] && pe_bus.config_valid === 1'b1) frames_held++;
      pe_bus.pe_ready = (i == 3);
      tick();
    end
    checks++;
    if (frames_held != 4) begin
      errors++;
      $display("FAIL stall hold: frame 1 held %0d cycles, want 4", frames_held);
    end
    pe_bus.pe_ready = 1'b1;
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (pe_bus.config_frame !== model_mem[k % 3] || ctx_ptr !== 4'(k % 3)) begin
        errors++;
        $display("FAIL stall seq k=%0d: frame=%h ptr=%0d, want %h ptr=%0d",
                 k, pe_bus.config_frame, ctx_ptr, model_mem[k % 3], k % 3);
      end
      tick();
    end
    pe_bus.pe_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall done: done=%b busy=%b, want 1 0", done, busy);
    end
`ifdef CGRA_CTX_PERF_EN
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL stall count: got %0d, want 3", stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_start_err();
    int bad [2] = '{0, 17};
    for (int i = 0; i < 2; i++) begin
      pulse_start(bad[i], 1);
      checks++;
      if (start_err !== 1'b1 || busy !== 1'b0 || pe_bus.config_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_err len=%0d: start_err=%b busy=%b valid=%b, want 1 0 0",
                 bad[i], start_err, busy, pe_bus.config_valid);
      end
      tick();
      checks++;
      if (start_err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL start_err pulse len=%0d: start_err=%b busy=%b, want 0 0", bad[i], start_err, busy);
      end
    end
  endtask

  task automatic test_forever_stop();
    program_entries(2);
    run_stream(2, 0, 40, 80, "forever");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (pe_bus.config_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        ctx_ptr !== 4'd0 || loop_iter !== 16'd20) begin
      errors++;
      $display("FAIL stop: valid=%b busy=%b done=%b ptr=%0d iter=%0d, want 0 0 0 0 20",
               pe_bus.config_valid, busy, done, ctx_ptr, loop_iter);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stop no-done: done=%b, want 0", done);
    end
  endtask

  task automatic test_wr_in_run();
    program_entries(3);
    pulse_start(3, 2);
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_data = ~model_mem[1];
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_err !== 1'b1 || pe_bus.config_frame !== model_mem[0]) begin
      errors++;
      $display("FAIL wr_err: wr_err=%b frame=%h, want 1 %h", wr_err, pe_bus.config_frame, model_mem[0]);
    end
    pe_bus.pe_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (pe_bus.config_frame !== model_mem[k % 3] || (k > 0 && wr_err !== 1'b0)) begin
        errors++;
        $display("FAIL wr_in_run replay k=%0d: frame=%h wr_err=%b, want %h 0",
                 k, pe_bus.config_frame, wr_err, model_mem[k % 3]);
      end
      tick();
    end
    pe_bus.pe_ready = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_run();
    program_entries(3);
    pulse_start(3, 0);
    pe_bus.pe_ready = 1'b1;
    tick();
    tick();
    pe_bus.pe_ready = 1'b0;
    checks++;
    if (ctx_ptr !== 4'd2) begin
      errors++;
      $display("FAIL rst_mid setup: ptr=%0d, want 2", ctx_ptr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pe_bus.config_frame !== 64'd0 || pe_bus.config_valid !== 1'b0 || busy !== 1'b0 ||
        ctx_ptr !== 4'd0 || loop_iter !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: frame=%h valid=%b busy=%b ptr=%0d iter=%0d done=%b, want all 0",
               pe_bus.config_frame, pe_bus.config_valid, busy, ctx_ptr, loop_iter, done);
    end
    run_stream(3, 1, 3, 100, "after_rst");
  endtask

  task automatic test_write_start_same_cycle();
    logic [63:0] fresh = {$urandom, $urandom};
    wr_en      = 1'b1;
    wr_addr    = 4'd0;
    wr_data    = fresh;
    ctx_len    = 5'd1;
    loop_count = 16'd1;
    start      = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    model_mem[0] = fresh;
    checks++;
    if (pe_bus.config_frame !== fresh || pe_bus.config_valid !== 1'b1) begin
      errors++;
      $display("FAIL write+start: frame=%h valid=%b, want %h 1", pe_bus.config_frame, pe_bus.config_valid, fresh);
    end
    pe_bus.pe_ready = 1'b1;
    stop = 1'b1;
    tick();
    pe_bus.pe_ready = 1'b0;
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || pe_bus.config_valid !== 1'b0 || loop_iter !== 16'd1) begin
      errors++;
      $display("FAIL stop+last: done=%b valid=%b iter=%0d, want 1 0 1", done, pe_bus.config_valid, loop_iter);
    end
    tick();
  endtask

  task automatic test_random_runs();
    int len;
    for (int r = 0; r < 6; r++) begin
      program_entries(16);
      len = (r == 0) ? 1 : (r == 1) ? 16 : $urandom_range(1, 16);
      run_stream(len, $urandom_range(1, 3), 0, 60, "random_probe");
    end
  endtask

  task automatic test_random_full();
    int len;
    int loops;
    for (int r = 0; r < 6; r++) begin
      program_entries(16);
      len   = (r == 0) ? 1 : (r == 1) ? 16 : $urandom_range(1, 16);
      loops = $urandom_range(1, 3);
      run_stream(len, loops, len * loops, 60, "random");
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; ctx_len = '0; loop_count = '0;
    pe_bus.pe_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_start_err();
    test_forever_stop();
    test_wr_in_run();
    test_rst_mid_run();
    test_write_start_same_cycle();
    test_random_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
